// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters, the shared
// ALU arbiter and the result consumer.
//   req0_* / req1_* : valid/ready request channels (x, y, alusel, tag)
//   rsp_*           : registered result channel (z, id, tag) with valid/ready
// Modports:
//   master : requester/consumer side (drives requests and rsp_ready)
//   slave  : arbiter side (drives req ready and the result channel)
interface alu_arb_if #(
  parameter int XLEN = 64,
  parameter int TAGW = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_x;
  logic [XLEN-1:0] req0_y;
  logic [3:0]      req0_alusel;
  logic [TAGW-1:0] req0_tag;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_x;
  logic [XLEN-1:0] req1_y;
  logic [3:0]      req1_alusel;
  logic [TAGW-1:0] req1_tag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_z;
  logic            rsp_id;
  logic [TAGW-1:0] rsp_tag;

  modport master (
    output req0_valid, req0_x, req0_y, req0_alusel, req0_tag,
    output req1_valid, req1_x, req1_y, req1_alusel, req1_tag,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_z, rsp_id, rsp_tag
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_alusel, req0_tag,
    input  req1_valid, req1_x, req1_y, req1_alusel, req1_tag,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_z, rsp_id, rsp_tag
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU. Round-robin grant,
// one registered result stage with valid/ready backpressure and an id/tag so
// each requester can pick out its own results.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : alu_arb_if.slave (req0_*, req1_*, rsp_*)
// Optional (macro ALU_ARB_STATS_EN):
//   stats_clr : synchronous clear of the statistics counters
//   gnt_cnt0/1: accepted transfers per requester (saturating)
//   stall_cnt : cycles with rsp_valid & !rsp_ready (saturating)
// Opcode encodings: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9;
// any other alusel completes with z=0.

// Combinational ALU shared by both requesters.
module alu_arb_alu #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] z
);
  localparam int SHW = $clog2(XLEN);
  logic [SHW-1:0] sh;
  assign sh = y[SHW-1:0];

  always_comb begin
    z = '0;
    case (sel)
      4'd0: z = x + y;
      4'd1: z = x - y;
      4'd2: z = x << sh;
      4'd3: z = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      4'd4: z = {{(XLEN-1){1'b0}}, (x < y)};
      4'd5: z = x ^ y;
      4'd6: z = x >> sh;
      4'd7: z = $signed(x) >>> sh;
      4'd8: z = x | y;
      4'd9: z = x & y;
      default: z = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int XLEN = 64,
  parameter int TAGW = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ALU_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] gnt_cnt0,
  output logic [31:0] gnt_cnt1,
  output logic [31:0] stall_cnt,
`endif
  alu_arb_if.slave    bus
);
  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [3:0]      sel;
    logic [TAGW-1:0] tag;
  } req_t;

  req_t [1:0]      req;
  logic [1:0]      vld;
  logic [1:0]      gnt;
  logic            last_gnt;
  logic            can_accept;
  logic            win;
  req_t            pick;
  logic            op_ok;
  logic [XLEN-1:0] alu_z;
  logic [XLEN-1:0] res;

  assign vld    = {bus.req1_valid, bus.req0_valid};
  assign req[0] = '{x: bus.req0_x, y: bus.req0_y, sel: bus.req0_alusel, tag: bus.req0_tag};
  assign req[1] = '{x: bus.req1_x, y: bus.req1_y, sel: bus.req1_alusel, tag: bus.req1_tag};

  // Slot is free if empty or being drained this cycle; this is what lets a
  // new result overwrite the draining one with no bubble.
  assign can_accept = !bus.rsp_valid || bus.rsp_ready;

  // On contention the requester that did not win last goes; last_gnt=1 out
  // of reset hands the first tie to requester 0.
  always_comb begin
    gnt = 2'b00;
    if (!rst && can_accept) begin
      if (&vld) gnt = last_gnt ? 2'b01 : 2'b10;
      else      gnt = vld;
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  assign win  = gnt[1];
  assign pick = req[win];

  alu_arb_alu #(.XLEN(XLEN)) u_alu (
    .x   (pick.x),
    .y   (pick.y),
    .sel (pick.sel),
    .z   (alu_z)
  );

  // Undefined opcodes are forced to zero here rather than trusting the ALU's
  // default arm, so the register can never capture a stale value.
  assign op_ok = pick.sel inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                  4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  assign res   = op_ok ? alu_z : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_z     <= '0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_tag   <= '0;
      last_gnt      <= 1'b1;
    end else if (|gnt) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_z     <= res;
      bus.rsp_id    <= win;
      bus.rsp_tag   <= pick.tag;
      last_gnt      <= win;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic stall;
  assign stall = bus.rsp_valid && !bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt[0] && gnt_cnt0  != 32'hFFFF_FFFF) gnt_cnt0  <= gnt_cnt0  + 32'd1;
      if (gnt[1] && gnt_cnt1  != 32'hFFFF_FFFF) gnt_cnt1  <= gnt_cnt1  + 32'd1;
      if (stall  && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. two issue slots or an integer pipe plus a multi-cycle helper unit.
- Round-robin arbitration on a valid/ready request handshake.
- One registered result stage with valid/ready backpressure, tagged so each requester can identify its own results.
- Sits between issue logic and writeback; instantiates the ALU internally.

Parameters:
- XLEN, 64, operand/result width passed to the internal ALU.
- TAGW, 4, width of the opaque tag carried from request to response.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_x  in  XLEN  operand x (signed).
- req0_y  in  XLEN  operand y.
- req0_alusel  in  4  operation select, const.h SEL_* encodings.
- req0_tag  in  TAGW  opaque tag.
- req1_valid / req1_ready / req1_x / req1_y / req1_alusel / req1_tag: same as requester 0, for requester 1.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_z  out  XLEN  ALU result.
- rsp_id  out  1  requester index that produced rsp_z.
- rsp_tag  out  TAGW  tag of that request.

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_z=0, rsp_id=0, rsp_tag=0, last_gnt=1 (requester 0 wins the first tie).
  - An in-flight or unconsumed result is discarded; nothing is replayed.
- While rst=1 the block accepts nothing: req0_ready=req1_ready=0.
- Slot free: can_accept = !rsp_valid | rsp_ready.
- Grant (combinational, one-hot or zero):
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Neither valid or !can_accept: no grant.
- reqN_ready = grantN. Ready depends on valid; requesters must not make valid depend on ready.
- Transfer: reqN_valid & reqN_ready at edge E. At E the block:
  - selects the operands of the granted requester into the ALU;
  - loads rsp_z, rsp_id=N, rsp_tag=reqN_tag;
  - sets rsp_valid=1 and last_gnt=N.
- Latency: result visible the cycle after acceptance (1 cycle).
- Throughput: 1 op/cycle while rsp_ready=1.
- Drain without refill: rsp_valid & rsp_ready with no grant -> rsp_valid=0 at the edge.
- Simultaneous drain and accept: the register is overwritten with the new result and rsp_valid stays 1. No bubble.
- Backpressure: while rsp_valid & !rsp_ready, rsp_z/rsp_id/rsp_tag are held stable and no request is granted.
- last_gnt changes only on an actual transfer; idle cycles and stalls do not move the pointer.
- Results leave in acceptance order; at most one op in flight, so no reordering.
- Opcode handling:
  - alusel not in the defined set (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND): the op is accepted and completes normally with rsp_z=0.
  - The arbiter decodes opcode validity itself and never latches a stale ALU output.
- Arithmetic and width rules are those of the ALU: full-width XLEN wrap-around on ADD/SUB, SLT signed, SLTU unsigned, compare results zero-extended to 1.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (each 32 bits): count accepted transfers per requester.
  - Adds output stall_cnt (32 bits): counts cycles with rsp_valid & !rsp_ready.
  - All three reset to 0 and saturate at 32'hFFFF_FFFF.
  - Adds input stats_clr (1): synchronous clear, priority over increment in the same cycle.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 alone: x=5, y=-7, alusel=ADD, tag=3, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_z=-2, rsp_id=0, rsp_tag=3.
- Both valid every cycle for 4 cycles, rsp_ready=1, req0 SUB 10-3, req1 XOR 0xF0^0x0F -> grants alternate 0,1,0,1; rsp_z alternates 7, 0xFF; first grant is requester 0 after reset.
- Backpressure: hold rsp_ready=0 for 3 cycles with rsp_valid=1, both requesters valid -> rsp_z/rsp_id/rsp_tag unchanged, req*_ready=0; on release, the same-cycle accept yields back-to-back valid with no bubble.
- Compares: SLT x=-1, y=1 -> rsp_z=1; SLTU same operands -> rsp_z=0; undefined alusel 4'hF -> rsp_z=0 with rsp_valid=1.
- Reset asserted while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, all rsp outputs 0, arbitration restarts with requester 0.
- With ALU_ARB_STATS_EN: 5 req0 transfers, 2 req1 transfers, 3 stall cycles -> gnt_cnt0=5, gnt_cnt1=2, stall_cnt=3; stats_clr pulse coinciding with a transfer -> all counters 0.
